block_aligner: RTL

Downstream stage of the sync-header seeker in the RD53B Aurora receive path. Consumes the 194-bit gearbox buffer together with the seeker's `is_synced`/`offset_pos` verdict. Extracts one 66-bit Aurora block per valid buffer, confirms and maintains block lock with a header-validation state machine, and presents 2-bit header plus 64-bit payload to the frame decoder.

---
 rtl/aurora_rx_pkg.sv | 22 ++
 rtl/block_aligner_descrambler.sv | 37 +++
 rtl/block_aligner.sv | 137 +++++++++++++
 3 files changed

// File: rtl/aurora_rx_pkg.sv
// Shared definitions for the Aurora receive path: sync-header codes,
// block/gearbox geometry and the block-alignment state encoding.
package aurora_rx_pkg;

  localparam logic [1:0] HDR_DATA   = 2'b01;
  localparam logic [1:0] HDR_CTRL   = 2'b10;
  localparam int         BLK_W      = 66;
  localparam int         GBOX_W     = 194;
  localparam int         MAX_OFFSET = 65;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECK    = 2'd1,
    LOCKED   = 2'd2
  } align_state_t;

  // A sync header is legal only for data (01) or control (10) blocks.
  function automatic logic hdr_is_valid(input logic [1:0] hdr);
    return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
  endfunction

endpackage

// File: rtl/block_aligner_descrambler.sv
// descrambler_58: Aurora self-synchronous descrambler, polynomial x^58+x^39+1.
// Only built when BLOCK_ALIGNER_DESCRAMBLE_EN is defined. Payload bit 0 is
// the earliest bit of the stream; the state holds the last 58 raw bits with
// index 0 the most recent.
`ifdef BLOCK_ALIGNER_DESCRAMBLE_EN
module descrambler_58 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [63:0] data_i,
  output logic [63:0] data_o
);

  logic [57:0] r_state;
  logic [57:0] w_state;

  // Each output bit cancels the scrambler taps 39 and 58 bits back in the raw stream.
  always_comb begin
    w_state = r_state;
    data_o  = '0;
    for (int i = 0; i < 64; i++) begin
      data_o[i] = data_i[i] ^ w_state[38] ^ w_state[57];
      w_state   = {w_state[56:0], data_i[i]};
    end
  end

  // State advances on every extracted block so it is primed before lock.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= '0;
    end else if (en_i) begin
      r_state <= w_state;
    end
  end

endmodule
`endif

// File: rtl/block_aligner.sv
// block_aligner: extracts one 66-bit Aurora block per valid gearbox buffer at
// the latched seeker offset, acquires and maintains block lock, and presents
// header/payload to the frame decoder.
// Optional: BLOCK_ALIGNER_DESCRAMBLE_EN routes the payload through descrambler_58.
module block_aligner
  import aurora_rx_pkg::*;
#(
  parameter int GOOD_CNT = 16,
  parameter int WIN_LEN  = 64,
  parameter int BAD_MAX  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [GBOX_W-1:0] gbox_buffer,
  input  logic              buffer_dv,
  input  logic              is_synced,
  input  logic [6:0]        offset_pos,
  output logic [1:0]        header_o,
  output logic [63:0]       data_o,
  output logic              data_valid_o,
  output logic              locked_o,
  output logic              lock_lost_o,
  output logic [15:0]       bad_hdr_cnt_o
);

  localparam int GOOD_W = $clog2(GOOD_CNT + 1);
  localparam int WIN_W  = $clog2(WIN_LEN + 1);
  localparam int BAD_W  = $clog2(BAD_MAX + 1);
  localparam logic [GOOD_W-1:0] GOOD_TGT = GOOD_W'(GOOD_CNT);
  localparam logic [WIN_W-1:0]  WIN_TGT  = WIN_W'(WIN_LEN);
  localparam logic [BAD_W-1:0]  BAD_TGT  = BAD_W'(BAD_MAX);

  align_state_t      r_state;
  logic [6:0]        r_off;
  logic [GOOD_W-1:0] r_good;
  logic [WIN_W-1:0]  r_win;
  logic [BAD_W-1:0]  r_bad;

  logic [7:0]        w_idx;
  logic [BLK_W-1:0]  w_blk;
  logic [1:0]        w_hdr;
  logic [63:0]       w_payload;
  logic [63:0]       w_data;
  logic              w_hdr_ok;
  logic              w_off_ok;
  logic [GOOD_W-1:0] w_good_inc;
  logic [WIN_W-1:0]  w_win_inc;
  logic [BAD_W-1:0]  w_bad_inc;

  // Extraction always uses the latched offset, never the live seeker value.
  assign w_idx      = {1'b0, r_off};
  assign w_blk      = gbox_buffer[w_idx +: BLK_W];
  assign w_hdr      = w_blk[65:64];
  assign w_payload  = w_blk[63:0];
  assign w_hdr_ok   = hdr_is_valid(w_hdr);
  assign w_off_ok   = (offset_pos <= 7'(MAX_OFFSET));
  assign w_good_inc = r_good + 1'b1;
  assign w_win_inc  = r_win + 1'b1;
  assign w_bad_inc  = r_bad + BAD_W'(!w_hdr_ok);
  assign locked_o   = (r_state == LOCKED);

`ifdef BLOCK_ALIGNER_DESCRAMBLE_EN
  descrambler_58 u_descrambler (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (buffer_dv),
    .data_i (w_payload),
    .data_o (w_data)
  );
`else
  assign w_data = w_payload;
`endif

  // Lock FSM with registered outputs; only blocks with buffer_dv move it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= UNLOCKED;
      r_off         <= '0;
      r_good        <= '0;
      r_win         <= '0;
      r_bad         <= '0;
      header_o      <= '0;
      data_o        <= '0;
      data_valid_o  <= 1'b0;
      lock_lost_o   <= 1'b0;
      bad_hdr_cnt_o <= '0;
    end else begin
      data_valid_o <= 1'b0;
      lock_lost_o  <= 1'b0;
      if (buffer_dv) begin
        unique case (r_state)
          UNLOCKED: begin
            // An out-of-range offset is treated as no sync verdict.
            if (is_synced && w_off_ok) begin
              r_off   <= offset_pos;
              r_good  <= '0;
              r_state <= CHECK;
            end
          end
          CHECK: begin
            if (!is_synced || !w_hdr_ok) begin
              r_state <= UNLOCKED;
            end else if (w_good_inc == GOOD_TGT) begin
              r_state <= LOCKED;
              r_win   <= '0;
              r_bad   <= '0;
            end else begin
              r_good <= w_good_inc;
            end
          end
          LOCKED: begin
            // Seeker inputs are ignored here; every block is presented,
            // including the one that drops lock.
            data_valid_o <= 1'b1;
            header_o     <= w_hdr;
            data_o       <= w_data;
            if (!w_hdr_ok && (bad_hdr_cnt_o != 16'hFFFF)) begin
              bad_hdr_cnt_o <= bad_hdr_cnt_o + 16'd1;
            end
            if (w_bad_inc == BAD_TGT) begin
              r_state     <= UNLOCKED;
              lock_lost_o <= 1'b1;
            end else if (w_win_inc == WIN_TGT) begin
              r_win <= '0;
              r_bad <= '0;
            end else begin
              r_win <= w_win_inc;
              r_bad <= w_bad_inc;
            end
          end
          default: r_state <= UNLOCKED;
        endcase
      end
    end
  end

endmodule
